uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter that responds on the processor's data-memory bus (`MemWrite`, `MemRead`, `DataAdr`, `WriteData`, `ReadData`). It sits beside the data memory in the top level and claims a 16-byte address window. Stores to its data register queue bytes in an internal FIFO, and a bit-timing state machine serialises them as 8N1 frames on `tx`. Read data is combinational so it fits the single-cycle load path. The top level ORs `ReadData` with data memory, gated by `sel`.

## Interface
- `BASE_ADDR`, 32'h0000_1000: base of the 16-byte register window; bits [3:0] must be 0.
- `FIFO_DEPTH`, 8: number of TX FIFO entries; must be a power of two, 2..128.
- `DEFAULT_DIV`, 16'd867: reset value of BAUDDIV. Bit period = BAUDDIV+1 clocks.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemWrite`  in  1  store strobe; acts on the clock edge.
- `MemRead`  in  1  load strobe; qualifies `ReadData`.
- `DataAdr`  in  32  byte address; word accesses only, bits [1:0] ignored.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  combinational load data; 0 when not selected or `MemRead`=0.
- `sel`  out  1  combinational: `DataAdr[31:4] == BASE_ADDR[31:4]`.
- `tx`  out  1  registered serial output, idle high.
- `tx_idle`  out  1  registered: FIFO empty and FSM in IDLE.

## Operation
- Register map, selected by `DataAdr[3:2]`:
  - 0 TXDATA: a write pushes `WriteData[7:0]`; a read returns 0.
  - 1 STATUS: reads return bit0 busy (FSM≠IDLE), bit1 full, bit2 empty, bit3 overflow, bits[15:8] FIFO count, all other bits 0. Writing 1 to bit3 clears overflow; all other written bits are ignored.
  - 2 BAUDDIV: read/write, [15:0]; upper bits read 0.
  - 3: reserved. Reads return 0; writes are ignored.
- Writes take effect only when `sel & MemWrite`.
- FIFO:
  - Circular buffer with a count register running 0..FIFO_DEPTH.
  - A push while full (using the current-cycle count) is dropped and sets overflow, even if a pop happens on the same edge.
  - A simultaneous push and pop when not full and not empty leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on an edge with the FIFO not empty, pop the head into the shift register, latch BAUDDIV into the frame divider, and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: 8 bits, LSB first, one bit period each, tracked by a 3-bit index. After bit 7, go to STOP.
  - STOP: `tx`=1 for one bit period. At the end of STOP, if the FIFO is not empty, pop and go straight to START (back-to-back frames). Otherwise go to IDLE.
- Bit timer:
  - Counts 0..frame_div, then rolls over. Rollover marks the bit boundary.
  - BAUDDIV writes during a frame do not affect that frame; they apply from the next pop.
  - BAUDDIV=0 gives 1-clock bits.
- No bypass: a byte written while the FIFO is empty is always stored first and popped on the following edge.

## Timing
- Reset values: `tx`=1, `tx_idle`=1, FSM IDLE, FIFO empty (count 0, pointers 0), overflow 0, BAUDDIV=DEFAULT_DIV, bit timer 0.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. `tx` is high after the reset edge.
- Write to TXDATA at edge k with the FIFO empty and FSM idle:
  - count=1 visible after edge k.
  - Pop at edge k+1; `tx` goes low after edge k+1.
  - `tx_idle` falls after edge k (it is registered from next-state values).
- Frame length is 10×(frame_div+1) clocks.
- With a continuously non-empty FIFO, frames are back-to-back with no idle gap.
- `tx_idle` rises after the edge that ends the last STOP with the FIFO empty.
- `ReadData` and `sel` are purely combinational on the same cycle; there are no wait states.

## Test plan
- Reset then idle: after `reset` high for 2 cycles, `tx`=1, `tx_idle`=1, STATUS read = 0x0000_0004, BAUDDIV read = 867.
- Single byte: write BAUDDIV=3, then TXDATA=0xA5. Expect `tx` low for 4 clocks starting one edge after the write. Data bits sample 1,0,1,0,0,1,0,1 at 4-clock spacing. Stop bit high. `tx_idle` high 40 clocks after the pop.
- Back-to-back: with BAUDDIV=1, write 0x01, 0x02, 0x03 on consecutive stores. Expect three contiguous 20-clock frames with no idle high between stop and start. STATUS count reads 2 the cycle after the third write.
- Overflow: with BAUDDIV=100, write 10 bytes with FIFO_DEPTH=8.
  - The first byte is popped before write 2 is accepted, so 9 bytes are queued and 1 is dropped.
  - STATUS reads full=1 and overflow=1.
  - Writing STATUS=0x8 clears overflow to 0; full stays 1.
- Mid-frame BAUDDIV change and reset: during a frame at BAUDDIV=3, write BAUDDIV=7. The current frame keeps 4-clock bits and the next frame uses 8-clock bits. Assert `reset` in DATA: `tx`=1 and STATUS=0x4 after the edge.
- Decode: a load from BASE_ADDR+0x10 gives `sel`=0 and `ReadData`=0. A load from BASE_ADDR+0xC gives 0. Stores to both change no state.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus bundle shared by the core (master) and memory-mapped peripherals (slave).
// Signal names match the processor's bus so peripherals drop in beside data memory.
interface uart_tx_mmio_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        sel;

    modport master (
        output MemWrite, MemRead, DataAdr, WriteData,
        input  ReadData, sel
    );

    modport slave (
        input  MemWrite, MemRead, DataAdr, WriteData,
        output ReadData, sel
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a TXDATA/STATUS/BAUDDIV register window
// in front of a byte FIFO and a bit-timing FSM.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_mmio_if.slave    bus,
    output logic             tx,
    output logic             tx_idle
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    baud_q, baud_d;
    logic [15:0]    timer_q, timer_d;
    logic [15:0]    frame_div_q, frame_div_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           tx_q, tx_d;
    logic           tx_idle_q, tx_idle_d;

    logic           wr_en, push, pop, fifo_full, fifo_empty, bit_end;
    logic [1:0]     reg_idx;
    logic [31:0]    rdata;
    logic           unused_bits;

    assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData[31:16]};
    assign bus.sel     = (bus.DataAdr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx     = bus.DataAdr[3:2];
    assign wr_en       = bus.sel & bus.MemWrite;
    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign bit_end     = (timer_q == frame_div_q);
    assign tx          = tx_q;
    assign tx_idle     = tx_idle_q;

    always_comb begin
        rdata = '0;
        case (reg_idx)
            2'd1:    rdata = {16'b0, 8'(count_q), 4'b0, ovf_q, fifo_empty, fifo_full,
                              (state_q != S_IDLE)};
            2'd2:    rdata = {16'b0, baud_q};
            default: rdata = '0;
        endcase
        bus.ReadData = (bus.sel && bus.MemRead) ? rdata : '0;
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        baud_d      = baud_q;
        state_d     = state_q;
        timer_d     = timer_q;
        frame_div_d = frame_div_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (wr_en) begin
            case (reg_idx)
                2'd0: begin
                    // Full is judged on the current count, so a same-edge pop cannot rescue the push.
                    if (fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push              = 1'b1;
                        mem_d[wr_ptr_q]   = bus.WriteData[7:0];
                        wr_ptr_d          = wr_ptr_q + AW'(1);
                    end
                end
                2'd1:    if (bus.WriteData[3]) ovf_d = 1'b0;
                2'd2:    baud_d = bus.WriteData[15:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: if (!fifo_empty) pop = 1'b1;
            S_START: begin
                timer_d = timer_q + 16'd1;
                if (bit_end) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                timer_d = timer_q + 16'd1;
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                timer_d = timer_q + 16'd1;
                if (bit_end) begin
                    timer_d = '0;
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The divider is captured per frame so BAUDDIV writes only affect later frames.
        if (pop) begin
            shift_d     = mem_q[rd_ptr_q];
            frame_div_d = baud_q;
            timer_d     = '0;
            rd_ptr_d    = rd_ptr_q + AW'(1);
            state_d     = S_START;
        end

        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        tx_idle_d = (count_d == '0) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            baud_q      <= DEFAULT_DIV;
            timer_q     <= '0;
            frame_div_q <= DEFAULT_DIV;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            tx_idle_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            baud_q      <= baud_d;
            timer_q     <= timer_d;
            frame_div_q <= frame_div_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            tx_idle_q   <= tx_idle_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register-access vector table, plus a serial-line
// monitor that checks each frame against bytes queued when they were stored.
module tb_uart_tx_mmio;
    localparam logic [31:0] B = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx, tx_idle;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR   (B),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd867)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .tx      (tx),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
    } sb_t;
    sb_t         sb[$];
    int unsigned start_log[$];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[15];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic sb_push(input logic [7:0] d, input logic [15:0] div);
        sb_t e;
        e.data = d;
        e.div  = div;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        #1 bus.MemWrite = 1'b0;
    endtask

    // Caller positions at a negedge; ReadData is combinational so no edge is consumed.
    task automatic chk_rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        bus.DataAdr = adr;
        bus.MemRead = 1'b1;
        #1 check1(name, bus.ReadData, exp);
        bus.MemRead = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max_cyc);
        int unsigned n = 0;
        @(negedge clk);
        while (!tx_idle && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check1("idle_wait", {31'b0, tx_idle}, 32'd1);
    endtask

    // Serial monitor: every cycle of a frame is compared with the expected level.
    int unsigned cyc = 0;
    bit          in_frame = 0;
    int unsigned fc, fp, bad;
    logic [9:0]  fexp;
    logic [7:0]  act;
    sb_t         cur;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            in_frame = 0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                start_log.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL frame_unexpected: got start bit at cycle %0d expected none", cyc);
                    cur.data = 8'h00;
                    cur.div  = 16'd0;
                end else begin
                    cur = sb.pop_front();
                end
                fp = cur.div + 1;
                fexp = {1'b1, cur.data, 1'b0};
                fc = 0;
                bad = 0;
                act = '0;
                in_frame = 1;
            end
            if (in_frame) begin
                if (tx !== fexp[fc / fp]) bad++;
                if ((fc % fp) == (fp / 2) && (fc / fp) >= 1 && (fc / fp) <= 8)
                    act[(fc / fp) - 1] = tx;
                fc++;
                if (fc == 10 * fp) begin
                    checks++;
                    if (bad == 0 && act === cur.data) passes++;
                    else $display("FAIL frame: got byte %h (%0d bad cycles) expected byte %h at div %0d",
                                  act, bad, cur.data, cur.div);
                    in_frame = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b1, B + 32'h4,  32'h0,         1'b1, 32'h0000_0004};
        vecs[1]  = '{1'b0, 1'b1, B + 32'h8,  32'h0,         1'b1, 32'd867};
        vecs[2]  = '{1'b0, 1'b1, B + 32'h0,  32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, B + 32'hC,  32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, B + 32'h10, 32'h0,         1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, B + 32'h10, 32'h0000_00FF, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, B + 32'hC,  32'h0000_0005, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, B + 32'h4,  32'hFFFF_FFF7, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, B + 32'h4,  32'h0,         1'b1, 32'h0000_0004};
        vecs[9]  = '{1'b0, 1'b1, B + 32'h7,  32'h0,         1'b1, 32'h0000_0004};
        vecs[10] = '{1'b1, 1'b0, B + 32'h8,  32'hABCD_0005, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b1, B + 32'h8,  32'h0,         1'b1, 32'h0000_0005};
        vecs[12] = '{1'b0, 1'b0, B + 32'h4,  32'h0,         1'b1, 32'h0};
        vecs[13] = '{1'b1, 1'b0, B + 32'h8,  32'd867,       1'b1, 32'h0};
        vecs[14] = '{1'b0, 1'b1, B + 32'h8,  32'h0,         1'b1, 32'd867};

        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("reset_tx", {31'b0, tx}, 32'd1);
        check1("reset_idle", {31'b0, tx_idle}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.MemWrite  = vecs[i].we;
            bus.MemRead   = vecs[i].re;
            bus.DataAdr   = vecs[i].adr;
            bus.WriteData = vecs[i].wd;
            #1;
            check1($sformatf("vec%0d_sel", i), {31'b0, bus.sel}, {31'b0, vecs[i].exp_sel});
            check1($sformatf("vec%0d_rd", i), bus.ReadData, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            bus.MemWrite = 1'b0;
            bus.MemRead  = 1'b0;
        end
        @(negedge clk);
        check1("decode_tx", {31'b0, tx}, 32'd1);
        check1("decode_idle", {31'b0, tx_idle}, 32'd1);

        // Single byte at BAUDDIV=3.
        do_write(B + 32'h8, 32'd3);
        sb_push(8'hA5, 16'd3);
        do_write(B + 32'h0, 32'h0000_00A5);
        @(negedge clk);
        check1("single_tx_before_pop", {31'b0, tx}, 32'd1);
        check1("single_idle_fell", {31'b0, tx_idle}, 32'd0);
        chk_rd(B + 32'h4, 32'h0000_0100, "single_status_queued");
        @(negedge clk);
        check1("single_start_low", {31'b0, tx}, 32'd0);
        repeat (39) @(negedge clk);
        check1("single_idle_last_stop", {31'b0, tx_idle}, 32'd0);
        @(negedge clk);
        check1("single_idle_rise", {31'b0, tx_idle}, 32'd1);

        // Back-to-back frames at BAUDDIV=1.
        do_write(B + 32'h8, 32'd1);
        start_log.delete();
        sb_push(8'h01, 16'd1);
        sb_push(8'h02, 16'd1);
        sb_push(8'h03, 16'd1);
        do_write(B + 32'h0, 32'h01);
        do_write(B + 32'h0, 32'h02);
        do_write(B + 32'h0, 32'h03);
        @(negedge clk);
        chk_rd(B + 32'h4, 32'h0000_0201, "b2b_status_count2");
        wait_idle(200);
        check1("b2b_frames", start_log.size(), 32'd3);
        if (start_log.size() == 3) begin
            check1("b2b_gap01", start_log[1] - start_log[0], 32'd20);
            check1("b2b_gap12", start_log[2] - start_log[1], 32'd20);
        end

        // BAUDDIV change mid-frame takes effect on the next frame only.
        do_write(B + 32'h8, 32'd3);
        start_log.delete();
        sb_push(8'h3C, 16'd3);
        sb_push(8'hC3, 16'd7);
        do_write(B + 32'h0, 32'h3C);
        do_write(B + 32'h0, 32'hC3);
        repeat (6) @(negedge clk);
        do_write(B + 32'h8, 32'd7);
        @(negedge clk);
        chk_rd(B + 32'h8, 32'd7, "midframe_baud_read");
        wait_idle(300);
        check1("midframe_frames", start_log.size(), 32'd2);
        if (start_log.size() == 2)
            check1("midframe_len1", start_log[1] - start_log[0], 32'd40);

        // Reset in the middle of a DATA bit.
        sb_push(8'hFF, 16'd7);
        do_write(B + 32'h0, 32'h0000_000F);
        repeat (20) @(negedge clk);
        check1("reset_mid_busy", {31'b0, tx_idle}, 32'd0);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check1("reset_mid_tx", {31'b0, tx}, 32'd1);
        check1("reset_mid_idle", {31'b0, tx_idle}, 32'd1);
        reset = 1'b0;
        chk_rd(B + 32'h4, 32'h0000_0004, "reset_mid_status");
        chk_rd(B + 32'h8, 32'd867, "reset_mid_baud");

        // Overflow: ten consecutive stores into an 8-deep FIFO.
        do_write(B + 32'h8, 32'd100);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb_push(8'(8'h10 + i), 16'd100);
            do_write(B + 32'h0, 32'(8'h10 + i));
        end
        @(negedge clk);
        chk_rd(B + 32'h4, 32'h0000_080B, "ovf_status_full");
        do_write(B + 32'h4, 32'h0000_0008);
        @(negedge clk);
        chk_rd(B + 32'h4, 32'h0000_0803, "ovf_cleared");
        wait_idle(12000);
        check1("sb_drained", sb.size(), 32'd0);
        check1("final_tx", {31'b0, tx}, 32'd1);
        @(negedge clk);
        chk_rd(B + 32'h4, 32'h0000_0004, "final_status");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
